// File: rtl/acc_bank_pkg.sv
// acc_bank shared definitions: op codes, flag indices,
// and the bank-select width helper.
package acc_bank_pkg;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_CLR     = 3'b100;
    localparam logic [2:0] OP_CLR_ALL = 3'b101;
    localparam logic [2:0] OP_INC     = 3'b110;
    localparam logic [2:0] OP_DEC     = 3'b111;

    localparam int FLAG_C  = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_N  = 2;
    localparam int FLAG_V  = 3;
    localparam int NFLAGS  = 4;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_bank_if.sv
// acc_bank operation port: op/sel/in from the ALU side,
// selected bank value, status flags and done back.
interface acc_bank_if
    import acc_bank_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4
);
    localparam int SEL_W = sel_width(NUM_ACC);

    logic [2:0]       op;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             done;

    modport master (
        output op, sel, in,
        input  out, carry, zero, negative, overflow, done
    );

    modport slave (
        input  op, sel, in,
        output out, carry, zero, negative, overflow, done
    );
endinterface

// File: rtl/acc_alu_core.sv
// acc_alu_core: WIDTH-bit add/sub with carry/borrow,
// signed overflow and optional unsigned saturation.
module acc_alu_core #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH:0] raw;

    // Extended-width sum/difference, flags from the raw result
    always_comb begin
        if (sub) begin
            raw = {1'b0, a} - {1'b0, b};
        end else begin
            raw = {1'b0, a} + {1'b0, b};
        end
        carry = raw[WIDTH];
        if (sub) begin
            overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                       (raw[WIDTH-1] != a[WIDTH-1]);
        end else begin
            overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                       (raw[WIDTH-1] != a[WIDTH-1]);
        end
        result = raw[WIDTH-1:0];
        if (SATURATE != 0 && carry) begin
            result = sub ? '0 : '1;
        end
    end
endmodule

// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC independent accumulators sharing one
// ALU core, global status flags and a done pulse.
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_ACC  = 4,
    parameter int SATURATE = 0
) (
    input logic        clock,
    input logic        reset,
    acc_bank_if.slave  bus
);
    localparam int SEL_W = sel_width(NUM_ACC);

    logic [WIDTH-1:0]  bank [NUM_ACC];
    logic [WIDTH-1:0]  cur;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  wr_data;
    logic [NFLAGS-1:0] flags;
    logic [NFLAGS-1:0] flags_nxt;
    logic              alu_c;
    logic              alu_v;
    logic              alu_sub;
    logic              sel_ok;
    logic              clr_all;
    logic              act;
    logic              done_q;

    assign sel_ok  = int'(bus.sel) < NUM_ACC;
    assign clr_all = (bus.op == OP_CLR_ALL);
    assign act     = (bus.op != OP_NOP) && (sel_ok || clr_all);
    assign alu_sub = (bus.op == OP_SUB) || (bus.op == OP_DEC);
    assign operand = (bus.op == OP_INC || bus.op == OP_DEC)
                   ? WIDTH'(1) : bus.in;

    // Selected bank read-out; out-of-range select reads zero
    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                cur = bank[i];
            end
        end
    end

    acc_alu_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .a        (cur),
        .b        (operand),
        .sub      (alu_sub),
        .result   (alu_res),
        .carry    (alu_c),
        .overflow (alu_v)
    );

    // Write data and next flags for the current op
    always_comb begin
        wr_data   = '0;
        flags_nxt = flags;
        case (bus.op)
            OP_LOAD: begin
                wr_data           = bus.in;
                flags_nxt         = '0;
                flags_nxt[FLAG_Z] = (bus.in == '0);
                flags_nxt[FLAG_N] = bus.in[WIDTH-1];
            end
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                wr_data           = alu_res;
                flags_nxt[FLAG_C] = alu_c;
                flags_nxt[FLAG_V] = alu_v;
                flags_nxt[FLAG_Z] = (alu_res == '0);
                flags_nxt[FLAG_N] = alu_res[WIDTH-1];
            end
            OP_CLR, OP_CLR_ALL: begin
                wr_data           = '0;
                flags_nxt         = '0;
                flags_nxt[FLAG_Z] = 1'b1;
            end
            default: begin
                wr_data   = '0;
                flags_nxt = flags;
            end
        endcase
    end

    // Bank array: clear-all, or write only the selected bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                bank[i] <= '0;
            end
        end else if (act) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (clr_all) begin
                    bank[i] <= '0;
                end else if (bus.sel == SEL_W'(i)) begin
                    bank[i] <= wr_data;
                end
            end
        end
    end

    // Global flags from the last accepted op, plus done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags         <= '0;
            flags[FLAG_Z] <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            done_q <= act;
            if (act) begin
                flags <= flags_nxt;
            end
        end
    end

    assign bus.out      = cur;
    assign bus.carry    = flags[FLAG_C];
    assign bus.zero     = flags[FLAG_Z];
    assign bus.negative = flags[FLAG_N];
    assign bus.overflow = flags[FLAG_V];
    assign bus.done     = done_q;
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: directed vectors on three acc_bank
// configurations (wrap, saturating, NUM_ACC = 3).
module tb_acc_bank;
    import acc_bank_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [1:0] sel;
        logic [7:0] din;
        logic [7:0] eout;
        logic [3:0] eflg;
        logic       edone;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op    = OP_NOP;
    logic [1:0] sel   = '0;
    logic [7:0] din   = '0;

    int checks   = 0;
    int failures = 0;

    vec_t vt [18];

    acc_bank_if #(.WIDTH(8), .NUM_ACC(4)) bw ();
    acc_bank_if #(.WIDTH(8), .NUM_ACC(4)) bs ();
    acc_bank_if #(.WIDTH(8), .NUM_ACC(3)) b3 ();

    assign bw.op = op;
    assign bw.sel = sel;
    assign bw.in = din;
    assign bs.op = op;
    assign bs.sel = sel;
    assign bs.in = din;
    assign b3.op = op;
    assign b3.sel = sel;
    assign b3.in = din;

    acc_bank #(.WIDTH(8), .NUM_ACC(4), .SATURATE(0)) u_wrap (
        .clock (clock),
        .reset (reset),
        .bus   (bw)
    );
    acc_bank #(.WIDTH(8), .NUM_ACC(4), .SATURATE(1)) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bs)
    );
    acc_bank #(.WIDTH(8), .NUM_ACC(3), .SATURATE(0)) u_three (
        .clock (clock),
        .reset (reset),
        .bus   (b3)
    );

    wire [3:0] fw = {bw.overflow, bw.negative, bw.zero, bw.carry};
    wire [3:0] fs = {bs.overflow, bs.negative, bs.zero, bs.carry};
    wire [3:0] f3 = {b3.overflow, b3.negative, b3.zero, b3.carry};

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [1:0] s,
                         input logic [7:0] d);
        @(negedge clock);
        op  = o;
        sel = s;
        din = d;
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input logic [1:0] s);
        @(negedge clock);
        op  = OP_NOP;
        sel = s;
        #1;
    endtask

    initial begin
        vt[0]  = '{OP_LOAD,    2'd0, 8'h10, 8'h10, 4'b0000, 1'b1};
        vt[1]  = '{OP_LOAD,    2'd1, 8'h20, 8'h20, 4'b0000, 1'b1};
        vt[2]  = '{OP_ADD,     2'd0, 8'h05, 8'h15, 4'b0000, 1'b1};
        vt[3]  = '{OP_NOP,     2'd1, 8'h00, 8'h20, 4'b0000, 1'b0};
        vt[4]  = '{OP_NOP,     2'd0, 8'h00, 8'h15, 4'b0000, 1'b0};
        vt[5]  = '{OP_LOAD,    2'd3, 8'hFF, 8'hFF, 4'b0100, 1'b1};
        vt[6]  = '{OP_INC,     2'd3, 8'h00, 8'h00, 4'b0011, 1'b1};
        vt[7]  = '{OP_DEC,     2'd3, 8'h00, 8'hFF, 4'b0101, 1'b1};
        vt[8]  = '{OP_LOAD,    2'd0, 8'h7F, 8'h7F, 4'b0000, 1'b1};
        vt[9]  = '{OP_ADD,     2'd0, 8'h01, 8'h80, 4'b1100, 1'b1};
        vt[10] = '{OP_SUB,     2'd0, 8'h01, 8'h7F, 4'b1000, 1'b1};
        vt[11] = '{OP_CLR,     2'd0, 8'h00, 8'h00, 4'b0010, 1'b1};
        vt[12] = '{OP_NOP,     2'd1, 8'h00, 8'h20, 4'b0010, 1'b0};
        vt[13] = '{OP_ADD,     2'd1, 8'hF0, 8'h10, 4'b0001, 1'b1};
        vt[14] = '{OP_SUB,     2'd1, 8'h20, 8'hF0, 4'b0101, 1'b1};
        vt[15] = '{OP_CLR_ALL, 2'd2, 8'h00, 8'h00, 4'b0010, 1'b1};
        vt[16] = '{OP_NOP,     2'd1, 8'h00, 8'h00, 4'b0010, 1'b0};
        vt[17] = '{OP_NOP,     2'd3, 8'h00, 8'h00, 4'b0010, 1'b0};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", bw.out, 8'h00);
        chk("rst_flags", {4'b0, fw}, 8'h02);
        chk("rst_done", {7'b0, bw.done}, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        // reset asserted between edges after a load
        do_op(OP_LOAD, 2'd2, 8'h5A);
        chk("pre_rst_out", bw.out, 8'h5A);
        chk("pre_rst_done", {7'b0, bw.done}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", bw.out, 8'h00);
        chk("arst_flags", {4'b0, fw}, 8'h02);
        chk("arst_done", {7'b0, bw.done}, 8'h00);
        chk("arst_out3", b3.out, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_op(vt[i].op, vt[i].sel, vt[i].din);
            chk($sformatf("v%0d_out", i), bw.out, vt[i].eout);
            chk($sformatf("v%0d_flags", i), {4'b0, fw},
                {4'b0, vt[i].eflg});
            chk($sformatf("v%0d_done", i), {7'b0, bw.done},
                {7'b0, vt[i].edone});
        end

        // saturation vs. wrap on the same stimulus
        do_op(OP_LOAD, 2'd1, 8'hF0);
        do_op(OP_ADD, 2'd1, 8'h20);
        chk("sat_add_out", bs.out, 8'hFF);
        chk("sat_add_flags", {4'b0, fs}, 8'h05);
        chk("wrap_add_out", bw.out, 8'h10);
        chk("wrap_add_flags", {4'b0, fw}, 8'h01);
        do_op(OP_LOAD, 2'd1, 8'h05);
        do_op(OP_SUB, 2'd1, 8'h09);
        chk("sat_sub_out", bs.out, 8'h00);
        chk("sat_sub_flags", {4'b0, fs}, 8'h03);
        chk("wrap_sub_out", bw.out, 8'hFC);
        chk("wrap_sub_flags", {4'b0, fw}, 8'h05);
        do_op(OP_LOAD, 2'd2, 8'hFF);
        do_op(OP_INC, 2'd2, 8'h00);
        chk("sat_inc_out", bs.out, 8'hFF);
        chk("sat_inc_flags", {4'b0, fs}, 8'h05);
        do_op(OP_LOAD, 2'd2, 8'h00);
        do_op(OP_DEC, 2'd2, 8'h00);
        chk("sat_dec_out", bs.out, 8'h00);
        chk("sat_dec_flags", {4'b0, fs}, 8'h03);
        do_op(OP_ADD, 2'd2, 8'h30);
        chk("sat_noclamp", bs.out, 8'h30);

        // NUM_ACC = 3: clear-all and out-of-range select
        do_op(OP_LOAD, 2'd0, 8'h11);
        do_op(OP_LOAD, 2'd1, 8'h22);
        do_op(OP_LOAD, 2'd2, 8'h33);
        chk("n3_load", b3.out, 8'h33);
        do_op(OP_CLR_ALL, 2'd1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            peek(2'(i));
            chk($sformatf("n3_clr_b%0d", i), b3.out, 8'h00);
        end
        do_op(OP_LOAD, 2'd2, 8'h77);
        chk("n3_b2", b3.out, 8'h77);
        do_op(OP_LOAD, 2'd3, 8'h44);
        chk("n3_bad_out", b3.out, 8'h00);
        chk("n3_bad_done", {7'b0, b3.done}, 8'h00);
        chk("n3_bad_flags", {4'b0, f3}, 8'h00);
        chk("n3_ok_done", {7'b0, bw.done}, 8'h01);
        do_op(OP_NOP, 2'd2, 8'h00);
        chk("n3_b2_kept", b3.out, 8'h77);
        peek(2'd0);
        chk("n3_b0_kept", b3.out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
